// File: rtl/prince_sbox_cms_ctrl.sv
// Issue/write-back sequencer for a shared, pipelined masked PRINCE S-box.
// Optional macro RND_STALL_EN: stall nibble issue while fresh randomness is unavailable.
module prince_sbox_cms_ctrl #(
  parameter int NIB = 16,
  parameter int LAT = 2
) (
  input  logic       i_clk,
  input  logic       i_rst,
  input  logic       i_start,
  input  logic       i_inv,
  input  logic       i_rnd_vld,
  output logic       o_busy,
  output logic       o_done,
  output logic       o_sbox_vld,
  output logic [3:0] o_nib_sel,
  output logic       o_rnd_req,
  output logic       o_inv,
  output logic       o_wr_en,
  output logic [3:0] o_wr_idx
);

  typedef enum logic [1:0] {IDLE, ISSUE, DRAIN, DONE} state_t;

  localparam logic [3:0] LAST = 4'(NIB - 1);

  state_t             state, state_nxt;
  logic [3:0]         cnt, cnt_nxt;
  logic               inv_q;
  logic               issue_en, issue;
  logic [LAT-1:0]     vld_pipe;
  logic [LAT-1:0][3:0] idx_pipe;

`ifdef RND_STALL_EN
  assign issue_en = i_rnd_vld;
`else
  logic unused_rnd;
  assign unused_rnd = i_rnd_vld;
  assign issue_en   = 1'b1;
`endif

  always_comb begin
    state_nxt = state;
    cnt_nxt   = cnt;
    issue     = 1'b0;
    case (state)
      IDLE: if (i_start) begin
        state_nxt = ISSUE;
        cnt_nxt   = 4'd0;
      end
      ISSUE: if (issue_en) begin
        issue = 1'b1;
        // counter parks on the last index instead of wrapping
        if (cnt == LAST) state_nxt = DRAIN;
        else             cnt_nxt   = cnt + 4'd1;
      end
      DRAIN: if (vld_pipe[LAT-1] && idx_pipe[LAT-1] == LAST) state_nxt = DONE;
      DONE:  state_nxt = IDLE;
      default: state_nxt = IDLE;
    endcase
  end

  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      state    <= IDLE;
      cnt      <= 4'd0;
      inv_q    <= 1'b0;
      vld_pipe <= '0;
      idx_pipe <= '0;
    end else begin
      state <= state_nxt;
      cnt   <= cnt_nxt;
      if (state == IDLE && i_start) inv_q <= i_inv;
      // tracks the S-box register stages; never stalls
      vld_pipe[0] <= issue;
      idx_pipe[0] <= issue ? cnt : 4'd0;
      for (int i = 1; i < LAT; i++) begin
        vld_pipe[i] <= vld_pipe[i-1];
        idx_pipe[i] <= idx_pipe[i-1];
      end
    end
  end

  assign o_busy     = (state != IDLE);
  assign o_done     = (state == DONE);
  assign o_sbox_vld = issue;
  assign o_rnd_req  = issue;
  assign o_nib_sel  = issue ? cnt : 4'd0;
  assign o_inv      = inv_q;
  assign o_wr_en    = vld_pipe[LAT-1];
  assign o_wr_idx   = idx_pipe[LAT-1];

endmodule
